// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences one Zicsr instruction through read, optional write and response
module csr_access_unit #(
    parameter int RO_WRITE_TRAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_csr_addr,
    input  logic [4:0]  req_rs1_idx,
    input  logic [31:0] req_rs1_data,
    input  logic [4:0]  req_rd_idx,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_we,
    input  logic [31:0] csr_rdata,
    input  logic        csr_valid,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [4:0]  rsp_rd_idx,
    output logic [31:0] rsp_rd_data,
    output logic        rsp_rd_we,
    output logic        rsp_illegal,
    output logic        instret_inc
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t      state;
    logic [2:0]  f3_q;
    logic [4:0]  rs1_idx_q;
    logic [31:0] rs1_data_q;
    logic [31:0] src;
    logic [31:0] new_val;
    logic        wr_att;
    logic        illegal;
    // new value, write-attempt and legality from the latched request and the live CSR read
    always_comb begin
        src     = f3_q[2] ? {27'b0, rs1_idx_q} : rs1_data_q;
        new_val = f3_q[1:0] == 2'b01 ? src : f3_q[1:0] == 2'b10 ? (csr_rdata | src) : (csr_rdata & ~src);
        wr_att  = f3_q[1:0] == 2'b01 || rs1_idx_q != 5'd0;
        illegal = !csr_valid || f3_q[1:0] == 2'b00 || (RO_WRITE_TRAP != 0 && csr_addr[11:10] == 2'b11 && wr_att);
    end
    assign instret_inc = rsp_valid && rsp_ready && !rsp_illegal;
    // request/read/write/response sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            csr_we      <= 1'b0;
            csr_wdata   <= '0;
            csr_addr    <= '0;
            rsp_valid   <= 1'b0;
            rsp_rd_idx  <= '0;
            rsp_rd_data <= '0;
            rsp_rd_we   <= 1'b0;
            rsp_illegal <= 1'b0;
            f3_q        <= '0;
            rs1_idx_q   <= '0;
            rs1_data_q  <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    csr_addr   <= req_csr_addr;
                    f3_q       <= req_funct3;
                    rs1_idx_q  <= req_rs1_idx;
                    rs1_data_q <= req_rs1_data;
                    rsp_rd_idx <= req_rd_idx;
                    req_ready  <= 1'b0;
                    state      <= READ;
                end
                READ: begin
                    rsp_rd_data <= illegal ? 32'd0 : csr_rdata;
                    rsp_rd_we   <= !illegal && rsp_rd_idx != 5'd0;
                    rsp_illegal <= illegal;
                    if (wr_att && !illegal) begin
                        csr_we    <= 1'b1;
                        csr_wdata <= new_val;
                        state     <= WRITE;
                    end else begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                WRITE: begin
                    csr_we    <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: randomized and directed checks of csr_access_unit against a rule-level model
module tb_csr_access_unit;
    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid = 0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 0;
    logic [11:0] req_csr_addr = 0;
    logic [4:0]  req_rs1_idx = 0;
    logic [31:0] req_rs1_data = 0;
    logic [4:0]  req_rd_idx = 0;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_we;
    logic [31:0] csr_rdata = 0;
    logic        csr_valid = 0;
    logic        rsp_valid;
    logic        rsp_ready = 0;
    logic [4:0]  rsp_rd_idx;
    logic [31:0] rsp_rd_data;
    logic        rsp_rd_we;
    logic        rsp_illegal;
    logic        instret_inc;
    int errors = 0;
    int checks = 0;

    csr_access_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_csr_addr(req_csr_addr), .req_rs1_idx(req_rs1_idx), .req_rs1_data(req_rs1_data),
        .req_rd_idx(req_rd_idx), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_we(csr_we),
        .csr_rdata(csr_rdata), .csr_valid(csr_valid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rd_idx(rsp_rd_idx), .rsp_rd_data(rsp_rd_data), .rsp_rd_we(rsp_rd_we),
        .rsp_illegal(rsp_illegal), .instret_inc(instret_inc)
    );

    always #5 clk = ~clk;

    task automatic run_op(input string name, input logic [2:0] f3, input logic [11:0] a,
                          input logic [4:0] r1i, input logic [31:0] r1d, input logic [4:0] rd,
                          input logic [31:0] old, input logic v, input int hold, input bit noise);
        logic [31:0] src, enew, wd, snap_d;
        logic        writes, ill, ew, erd_we;
        logic [31:0] erd;
        int n, we_cnt;
        src = f3[2] ? 32'(r1i) : r1d;
        case (f3)
            3'd1, 3'd5: enew = src;
            3'd2, 3'd6: enew = old | src;
            default:    enew = old & ~src;
        endcase
        writes = (f3 == 3'd1 || f3 == 3'd5) || r1i != 0;
        ill    = !v || f3 == 3'd0 || f3 == 3'd4 || (a >= 12'hC00 && writes);
        ew     = writes && !ill;
        erd    = ill ? 32'd0 : old;
        erd_we = !ill && rd != 0;
        @(negedge clk);
        req_valid = 1; req_funct3 = f3; req_csr_addr = a; req_rs1_idx = r1i;
        req_rs1_data = r1d; req_rd_idx = rd; csr_rdata = old; csr_valid = v;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL %s req_ready got=%b exp=1", name, req_ready); end
        @(posedge clk); #1;
        req_valid = noise;
        req_funct3 = 3'($urandom); req_csr_addr = 12'($urandom); req_rs1_idx = 5'($urandom);
        req_rs1_data = $urandom; req_rd_idx = 5'($urandom);
        checks++;
        if (csr_addr !== a) begin errors++; $display("FAIL %s csr_addr got=%h exp=%h", name, csr_addr, a); end
        n = 0; we_cnt = 0; wd = 0;
        while (rsp_valid !== 1'b1 && n < 8) begin
            @(posedge clk); #1; n++;
            if (csr_we === 1'b1) begin we_cnt++; wd = csr_wdata; end
        end
        checks++;
        if (n != (ew ? 2 : 1)) begin errors++; $display("FAIL %s latency got=%0d exp=%0d", name, n, ew ? 2 : 1); end
        checks++;
        if (we_cnt != (ew ? 1 : 0)) begin errors++; $display("FAIL %s we_cycles got=%0d exp=%0d", name, we_cnt, ew ? 1 : 0); end
        if (ew) begin
            checks++;
            if (wd !== enew) begin errors++; $display("FAIL %s wdata got=%h exp=%h", name, wd, enew); end
        end
        snap_d = rsp_rd_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rd_data !== snap_d || instret_inc !== 1'b0 || csr_we !== 1'b0) begin
                errors++; $display("FAIL %s hold%0d valid=%b data=%h/%h instret=%b we=%b", name, i, rsp_valid, rsp_rd_data, snap_d, instret_inc, csr_we);
            end
        end
        @(negedge clk);
        req_valid = 0; rsp_ready = 1; #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rd_data !== erd) begin errors++; $display("FAIL %s rd_data got=%h valid=%b exp=%h", name, rsp_rd_data, rsp_valid, erd); end
        checks++;
        if (rsp_rd_we !== erd_we || rsp_illegal !== ill || rsp_rd_idx !== rd) begin
            errors++; $display("FAIL %s rsp we/ill/idx got=%b/%b/%0d exp=%b/%b/%0d", name, rsp_rd_we, rsp_illegal, rsp_rd_idx, erd_we, ill, rd);
        end
        checks++;
        if (instret_inc !== !ill) begin errors++; $display("FAIL %s instret got=%b exp=%b", name, instret_inc, !ill); end
        @(posedge clk); #1;
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || instret_inc !== 1'b0 || csr_we !== 1'b0) begin
            errors++; $display("FAIL %s after_hs valid=%b ready=%b instret=%b we=%b", name, rsp_valid, req_ready, instret_inc, csr_we);
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || csr_we !== 1'b0 || rsp_valid !== 1'b0 || instret_inc !== 1'b0) begin
            errors++; $display("FAIL reset ctrl ready=%b we=%b valid=%b instret=%b", req_ready, csr_we, rsp_valid, instret_inc);
        end
        checks++;
        if (rsp_rd_we !== 1'b0 || rsp_illegal !== 1'b0 || rsp_rd_data !== 32'd0 || rsp_rd_idx !== 5'd0) begin
            errors++; $display("FAIL reset rsp we=%b ill=%b data=%h idx=%0d", rsp_rd_we, rsp_illegal, rsp_rd_data, rsp_rd_idx);
        end
        checks++;
        if (csr_addr !== 12'd0 || csr_wdata !== 32'd0) begin
            errors++; $display("FAIL reset csr addr=%h wdata=%h", csr_addr, csr_wdata);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_directed;
        run_op("rs_ro_read", 3'b010, 12'hC00, 5'd0, 32'hDEAD_BEEF, 5'd7, 32'h1234, 1'b1, 0, 1'b0);
        run_op("rw_340", 3'b001, 12'h340, 5'd9, 32'h5555, 5'd3, 32'hAAAA_0000, 1'b1, 0, 1'b0);
        run_op("rc_340", 3'b011, 12'h340, 5'd4, 32'h0F, 5'd2, 32'hFF, 1'b1, 1, 1'b0);
        run_op("rsi_3", 3'b110, 12'h340, 5'd3, 32'hFFFF_FFFF, 5'd5, 32'h10, 1'b1, 0, 1'b0);
        run_op("rw_ro_trap", 3'b001, 12'hC01, 5'd6, 32'h77, 5'd8, 32'h9999, 1'b1, 0, 1'b0);
        run_op("invalid_7ff", 3'b010, 12'h7FF, 5'd0, 32'h0, 5'd1, 32'h4242, 1'b0, 5, 1'b0);
        run_op("bad_funct3", 3'b100, 12'h300, 5'd1, 32'h1, 5'd1, 32'h5, 1'b1, 0, 1'b0);
        run_op("rd_zero", 3'b101, 12'h305, 5'd31, 32'h0, 5'd0, 32'h8000_0000, 1'b1, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_op("busy_ignore", 3'b001, 12'h341, 5'd2, 32'h1357_9BDF, 5'd10, 32'h2468, 1'b1, 2, 1'b1);
        run_op("busy_ignore_rd", 3'b010, 12'hF11, 5'd0, 32'h0, 5'd11, 32'hCAFE, 1'b1, 0, 1'b1);
    endtask

    task automatic test_reset_in_write;
        @(negedge clk);
        req_valid = 1; req_funct3 = 3'b001; req_csr_addr = 12'h340; req_rs1_idx = 5'd1;
        req_rs1_data = 32'h1111; req_rd_idx = 5'd1; csr_rdata = 32'h2222; csr_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        checks++;
        if (csr_we !== 1'b1) begin errors++; $display("FAIL rst_wr in_write we got=%b exp=1", csr_we); end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        checks++;
        if (csr_we !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_wr after we=%b valid=%b ready=%b", csr_we, rsp_valid, req_ready);
        end
        rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (csr_we !== 1'b0 || rsp_valid !== 1'b0 || instret_inc !== 1'b0) begin
                errors++; $display("FAIL rst_wr idle%0d we=%b valid=%b instret=%b", i, csr_we, rsp_valid, instret_inc);
            end
        end
        rsp_ready = 0;
        run_op("post_reset", 3'b011, 12'h340, 5'd1, 32'h3, 5'd4, 32'h7, 1'b1, 0, 1'b0);
    endtask

    task automatic test_random;
        logic [2:0]  f3;
        logic [11:0] a;
        logic [4:0]  r1i;
        for (int k = 0; k < 30; k++) begin
            f3  = 3'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? {2'b11, 10'($urandom)} : 12'($urandom);
            r1i = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            run_op($sformatf("rand%0d", k), f3, a, r1i, $urandom, 5'($urandom), $urandom,
                   $urandom_range(0, 5) != 0, $urandom_range(0, 2), bit'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_reset_in_write;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
